// File: rtl/mips_if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_if_fetch_pkg
// Brief   : Shared widths, reset PC and branch-opcode constants for IF.
// Revision: 1.0 - initial release
// ============================================================================
package mips_if_fetch_pkg;

    localparam int MIPS_ADDR_WIDTH = 32;
    localparam int MIPS_INST_WIDTH = 32;

    localparam logic [MIPS_ADDR_WIDTH-1:0] c_reset_pc = 32'h0000_0000;

    // Conditional branches all live in the 6'b000xxx opcode group.
    localparam logic [2:0] c_op_branch_grp = 3'b000;
    localparam logic [2:0] c_op_regimm     = 3'b001;
    localparam logic [2:0] c_op_beq        = 3'b100;
    localparam logic [2:0] c_op_bne        = 3'b101;
    localparam logic [2:0] c_op_blez       = 3'b110;
    localparam logic [2:0] c_op_bgtz       = 3'b111;

    function automatic logic op_is_branch(input logic [5:0] op);
        return (op[5:3] == c_op_branch_grp) &&
               ((op[2:0] == c_op_regimm) || (op[2:0] == c_op_beq) ||
                (op[2:0] == c_op_bne)    || (op[2:0] == c_op_blez) ||
                (op[2:0] == c_op_bgtz));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_if_predecode.sv
`default_nettype none
// ============================================================================
// Module  : mips_if_predecode
// Brief   : Combinational BTFN predecode: backward conditional branches taken.
// Revision: 1.0 - initial release
// ============================================================================
module mips_if_predecode
    import mips_if_fetch_pkg::*;
(
    input  logic [MIPS_INST_WIDTH-1:0] inst,
    input  logic [MIPS_ADDR_WIDTH-1:0] pc,
    output logic                       is_branch,
    output logic                       prdt_taken,
    output logic [MIPS_ADDR_WIDTH-1:0] prdt_pc
);

    logic [MIPS_ADDR_WIDTH-1:0] w_offset;
    logic                       w_unused_fields;

    assign is_branch  = op_is_branch(inst[31:26]);
    // A negative displacement (imm[15] set) means a backward branch.
    assign prdt_taken = is_branch & inst[15];
    assign w_offset   = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign prdt_pc    = pc + 32'd4 + w_offset;

    assign w_unused_fields = ^inst[25:16];

endmodule
`default_nettype wire

// File: rtl/mips_if_fetch.sv
`default_nettype none
// ============================================================================
// Module  : mips_if_fetch
// Brief   : MIPS IF stage: PC, single-outstanding fetch FSM and IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
module mips_if_fetch
    import mips_if_fetch_pkg::*;
#(
    parameter logic [MIPS_ADDR_WIDTH-1:0] RESET_PC = c_reset_pc
)(
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ifu_req_valid,
    input  logic                       ifu_req_ready,
    output logic [MIPS_ADDR_WIDTH-1:0] ifu_req_addr,
    input  logic                       ifu_rsp_valid,
    output logic                       ifu_rsp_ready,
    input  logic [MIPS_INST_WIDTH-1:0] ifu_rsp_inst,
    input  logic                       id_stall,
    input  logic                       id_jump,
    input  logic [MIPS_ADDR_WIDTH-1:0] id_jump_pc,
    input  logic                       ex_flush,
    input  logic [MIPS_ADDR_WIDTH-1:0] ex_flush_pc,
    output logic                       if2id_valid,
    output logic [MIPS_INST_WIDTH-1:0] if2id_inst,
    output logic [MIPS_ADDR_WIDTH-1:0] if2id_pc,
    output logic [MIPS_ADDR_WIDTH-1:0] if2id_pc_incr,
    output logic                       if2id_prdt_taken
);

    localparam logic [0:0] c_st_req  = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    logic [0:0]                 r_state;
    logic [MIPS_ADDR_WIDTH-1:0] r_pc;
    logic                       r_kill;

    logic                       w_in_req;
    logic                       w_in_wait;
    logic                       w_rsp_hs;
    logic                       w_req_hs;
    logic                       w_live;
    logic                       w_redirect;
    logic [MIPS_ADDR_WIDTH-1:0] w_redirect_pc;
    logic [MIPS_ADDR_WIDTH-1:0] w_pc_incr;
    logic [MIPS_ADDR_WIDTH-1:0] w_pc_nxt;
    logic [MIPS_ADDR_WIDTH-1:0] w_prdt_pc;
    logic                       w_is_branch;
    logic                       w_prdt_taken;

    // In WAIT, r_pc is the address of the outstanding request (or the
    // redirect target once that request has been killed).
    mips_if_predecode u_predecode (
        .inst       (ifu_rsp_inst),
        .pc         (r_pc),
        .is_branch  (w_is_branch),
        .prdt_taken (w_prdt_taken),
        .prdt_pc    (w_prdt_pc)
    );

    assign w_in_req      = (r_state == c_st_req);
    assign w_in_wait     = (r_state == c_st_wait);
    assign ifu_rsp_ready = w_in_wait & (r_kill | ~if2id_valid | ~id_stall);
    assign w_rsp_hs      = ifu_rsp_valid & ifu_rsp_ready;
    assign w_live        = w_rsp_hs & ~r_kill;
    assign w_redirect    = ex_flush | id_jump;
    assign w_redirect_pc = ex_flush ? ex_flush_pc : id_jump_pc;
    assign w_pc_incr     = r_pc + 32'd4;
    assign w_pc_nxt      = (w_is_branch & w_prdt_taken) ? w_prdt_pc : w_pc_incr;

    // A live response chains the next request in the same cycle unless a
    // redirect discards it.
    assign ifu_req_valid = w_in_req | (w_live & ~w_redirect);
    assign ifu_req_addr  = w_in_req ? r_pc : w_pc_nxt;
    assign w_req_hs      = ifu_req_valid & ifu_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_req;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            case (r_state)
                c_st_req: begin
                    if (w_redirect) begin
                        r_pc <= w_redirect_pc;
                        if (w_req_hs) begin
                            r_state <= c_st_wait;
                            r_kill  <= 1'b1;
                        end
                    end else if (w_req_hs) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (w_redirect) begin
                        r_pc <= w_redirect_pc;
                        if (w_rsp_hs) begin
                            r_state <= c_st_req;
                            r_kill  <= 1'b0;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (w_rsp_hs) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= c_st_req;
                        end else begin
                            r_pc <= w_pc_nxt;
                            if (!w_req_hs) begin
                                r_state <= c_st_req;
                            end
                        end
                    end
                end
                default: r_state <= c_st_req;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if2id_valid      <= 1'b0;
            if2id_inst       <= '0;
            if2id_pc         <= '0;
            if2id_pc_incr    <= '0;
            if2id_prdt_taken <= 1'b0;
        end else if (w_redirect) begin
            if2id_valid <= 1'b0;
        end else if (w_live) begin
            if2id_valid      <= 1'b1;
            if2id_inst       <= ifu_rsp_inst;
            if2id_pc         <= r_pc;
            if2id_pc_incr    <= w_pc_incr;
            if2id_prdt_taken <= w_is_branch & w_prdt_taken;
        end else if (!id_stall) begin
            if2id_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_if_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_if_fetch
// Brief   : Randomized scoreboard bench for mips_if_fetch with a memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_if_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_inst = '0;
    logic        id_stall = 1'b0;
    logic        id_jump = 1'b0;
    logic [31:0] id_jump_pc = '0;
    logic        ex_flush = 1'b0;
    logic [31:0] ex_flush_pc = '0;
    logic        if2id_valid;
    logic [31:0] if2id_inst;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_pc_incr;
    logic        if2id_prdt_taken;

    always #5 clk = ~clk;

    mips_if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_valid    (ifu_req_valid),
        .ifu_req_ready    (ifu_req_ready),
        .ifu_req_addr     (ifu_req_addr),
        .ifu_rsp_valid    (ifu_rsp_valid),
        .ifu_rsp_ready    (ifu_rsp_ready),
        .ifu_rsp_inst     (ifu_rsp_inst),
        .id_stall         (id_stall),
        .id_jump          (id_jump),
        .id_jump_pc       (id_jump_pc),
        .ex_flush         (ex_flush),
        .ex_flush_pc      (ex_flush_pc),
        .if2id_valid      (if2id_valid),
        .if2id_inst       (if2id_inst),
        .if2id_pc         (if2id_pc),
        .if2id_pc_incr    (if2id_pc_incr),
        .if2id_prdt_taken (if2id_prdt_taken)
    );

    int          checks = 0;
    int          failures = 0;
    int          consumed = 0;
    int          idle = 0;
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic        s_req_hs = 1'b0;
    logic        s_rsp_hs = 1'b0;
    logic [31:0] s_req_addr = '0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_pc, hold_inst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Program image: a hand-built low region, hashed pseudo-random code above.
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] h;
        logic [5:0]  op;
        if (a < 32'h100) begin
            if (a == 32'h20) return {6'd5, 5'd1, 5'd2, 16'h0003};
            if (a == 32'h40) return {6'd4, 5'd0, 5'd0, 16'hFFFC};
            return 32'h0;
        end
        h = (a ^ 32'h5bd1_e995) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        case (h[2:0])
            3'd0: op = 6'd4;
            3'd1: op = 6'd5;
            3'd2: op = 6'd6;
            3'd3: op = 6'd7;
            3'd4: op = 6'd1;
            3'd5: op = 6'd2;
            3'd6: op = 6'd0;
            default: op = 6'd8;
        endcase
        return {op, h[31:22], h[15:0]};
    endfunction

    // Architectural next-instruction rule: BTFN on conditional branches only.
    task automatic push_next();
        exp_t        e;
        logic [31:0] off;
        logic [5:0]  op;
        e.pc   = m_pc;
        e.inst = memf(m_pc);
        op     = e.inst[31:26];
        e.taken = ((op == 6'd1) || (op == 6'd4) || (op == 6'd5) ||
                   (op == 6'd6) || (op == 6'd7)) && e.inst[15];
        off  = {{16{e.inst[15]}}, e.inst[15:0]};
        m_pc = e.taken ? (m_pc + 32'd4 + off * 32'd4) : (m_pc + 32'd4);
        exp_q.push_back(e);
    endtask

    // Monitor: samples handshakes and checks what ID consumes.
    always @(negedge clk) begin
        if (rst) begin
            s_req_hs  = 1'b0;
            s_rsp_hs  = 1'b0;
            hold_pend = 1'b0;
        end else begin
            s_req_hs   = ifu_req_valid & ifu_req_ready;
            s_req_addr = ifu_req_addr;
            s_rsp_hs   = ifu_rsp_valid & ifu_rsp_ready;
            if (hold_pend) begin
                chk("hold_valid", {31'd0, if2id_valid}, 32'd1);
                chk("hold_pc", if2id_pc, hold_pc);
                chk("hold_inst", if2id_inst, hold_inst);
            end
            hold_pend = if2id_valid & id_stall & ~ex_flush & ~id_jump;
            hold_pc   = if2id_pc;
            hold_inst = if2id_inst;
            if (if2id_valid && !id_stall) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", if2id_pc, e.pc);
                    chk("sb_inst", if2id_inst, e.inst);
                    chk("sb_pc_incr", if2id_pc_incr, e.pc + 32'd4);
                    chk("sb_prdt", {31'd0, if2id_prdt_taken}, {31'd0, e.taken});
                    consumed++;
                end
            end else begin
                idle++;
                if (idle == 400) chk("timeout_no_progress", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        logic        mem_busy;
        logic [31:0] mem_addr;
        int          mem_wait;
        logic        redir_pend;
        logic [31:0] redir_pc;
        logic        phase1;
        mem_busy   = 1'b0;
        mem_addr   = '0;
        mem_wait   = 0;
        redir_pend = 1'b0;
        redir_pc   = '0;
        m_pc       = 32'h0;
        while (exp_q.size() < 4) push_next();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
        rst = 1'b0;
        ifu_req_ready = 1'b1;
        #1;
        chk("rst_req_valid", {31'd0, ifu_req_valid}, 32'd1);
        chk("rst_req_addr", ifu_req_addr, 32'h0);
        chk("rst_rsp_ready2", {31'd0, ifu_rsp_ready}, 32'd0);
        chk("rst_if2id_valid", {31'd0, if2id_valid}, 32'd0);
        chk("rst_if2id_inst", if2id_inst, 32'd0);
        chk("rst_if2id_pc", if2id_pc, 32'd0);
        chk("rst_if2id_pc_incr", if2id_pc_incr, 32'd0);
        chk("rst_if2id_prdt", {31'd0, if2id_prdt_taken}, 32'd0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            phase1 = (cyc < 30);
            if (phase1) chk("throughput", {31'd0, s_req_hs}, 32'd1);
            if (s_rsp_hs) mem_busy = 1'b0;
            if (s_req_hs) begin
                chk("req_align", {30'd0, s_req_addr[1:0]}, 32'd0);
                chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
                if (redir_pend) begin
                    chk("redir_addr", s_req_addr, redir_pc);
                    redir_pend = 1'b0;
                end
                mem_busy = 1'b1;
                mem_addr = s_req_addr;
                mem_wait = phase1 ? 0 : int'($urandom_range(0, 2));
            end
            if (ex_flush || id_jump) begin
                exp_q.delete();
                m_pc       = ex_flush ? ex_flush_pc : id_jump_pc;
                redir_pend = 1'b1;
                redir_pc   = m_pc;
            end
            while (exp_q.size() < 4) push_next();

            if (mem_busy && mem_wait == 0) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_inst  = memf(mem_addr);
            end else begin
                ifu_rsp_valid = 1'b0;
                ifu_rsp_inst  = $urandom;
                if (mem_busy) mem_wait--;
            end

            if (phase1) begin
                ifu_req_ready = 1'b1;
                id_stall      = 1'b0;
                ex_flush      = 1'b0;
                id_jump       = 1'b0;
            end else if (cyc == 1500) begin
                ifu_req_ready = 1'b1;
                id_stall      = 1'b0;
                ex_flush      = 1'b1;
                ex_flush_pc   = 32'h200;
                id_jump       = 1'b1;
                id_jump_pc    = 32'h300;
            end else begin
                ifu_req_ready = ($urandom_range(0, 3) != 0);
                id_stall      = ($urandom_range(0, 3) == 0);
                ex_flush      = ($urandom_range(0, 15) == 0);
                ex_flush_pc   = {16'd0, 4'($urandom_range(0, 15)), 10'($urandom), 2'b00};
                id_jump       = ($urandom_range(0, 15) == 0);
                id_jump_pc    = {16'd0, 4'($urandom_range(0, 15)), 10'($urandom), 2'b00};
            end
        end
        chk("progress", {31'd0, (consumed > 200)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
